z80fi_insn_capture: RTL and testbench
=====================================

# z80fi_insn_capture

Collects the per-instruction formal-interface packet from the core's retire-side signals, upstream of every `z80fi_insn_spec_*` checker. It accumulates opcode bytes as the core fetches them, snapshots the register file at instruction start and at retire, and emits a one-cycle `z80fi_valid` packet carrying `z80fi_insn`, `z80fi_insn_len`, and the in/out register images. It also keeps a retired-instruction order counter and sticky protocol-error flags.

## Interface
- `MAX_LEN`, 4: maximum instruction length in bytes (fixes `z80fi_insn` width at 8*MAX_LEN).
- `ORDER_W`, 32: width of the retired-instruction counter.
- `clk` in 1: sole clock; all state changes on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `core_insn_start` in 1: first cycle of a new instruction (M1 of first opcode byte).
- `core_byte_valid` in 1: `core_byte` is an opcode/prefix/operand byte of the current instruction.
- `core_byte` in 8: fetched instruction byte.
- `core_retire` in 1: current instruction completes this cycle; `core_regs` holds final state.
- `core_regs` in 128: live registers {ip, sp, iy, ix, hl, de, bc, af}, af in [15:0], f in [7:0].
- `z80fi_valid` out 1: packet valid, one-cycle pulse.
- `z80fi_insn` out 8*MAX_LEN: instruction bytes, first byte in [7:0], byte k in [8k+7:8k], unused bytes zero.
- `z80fi_insn_len` out 3: byte count, 1..MAX_LEN.
- `z80fi_regs_in` out 128: `core_regs` sampled on the start cycle.
- `z80fi_regs_out` out 128: `core_regs` sampled on the retire cycle.
- `z80fi_order` out ORDER_W: index of this packet, first packet 0.
- `err_overflow` out 1: sticky; byte received with MAX_LEN already collected.
- `err_orphan` out 1: sticky; retire with no open instruction, or retire with zero bytes.
- `err_abandon` out 1: sticky; start while an instruction is open and not retiring.

## Operation
- States: IDLE (no open instruction), OPEN (collecting).
- IDLE + `core_insn_start` -> OPEN: clear byte buffer and count, latch `core_regs` into regs_in shadow. A `core_byte_valid` byte on the same cycle is stored as byte 0, count=1.
- OPEN + `core_byte_valid`: if count < MAX_LEN store at index count, count+1; else drop byte, set `err_overflow`.
- OPEN + `core_retire`, count>=1: load output packet (buffer incl. any same-cycle byte, count, regs_in shadow, `core_regs` as regs_out, order counter), order counter +1 (wraps at 2^ORDER_W), -> IDLE.
- OPEN + `core_retire`, count=0 (incl. same-cycle byte absent): no packet, set `err_orphan`, -> IDLE.
- Retire and start same cycle while OPEN: emit old packet as above, then open new instruction (new regs_in = same-cycle `core_regs`; same-cycle byte belongs to the NEW instruction) -> OPEN.
- OPEN + start without retire: discard old, set `err_abandon`, reopen.
- IDLE + `core_retire` (no start): set `err_orphan`, no packet. IDLE + byte without start: ignored, no error.
- Start+retire same cycle from IDLE with a byte: single-cycle instruction, emit len 1; regs_in = regs_out = `core_regs`.
- Error flags clear only on reset.

## Timing
- Packet outputs registered; `z80fi_valid` high exactly the cycle after `core_retire`, for one cycle; packet fields hold until next packet.
- Back-to-back retires on consecutive cycles yield consecutive valid pulses, no gaps.
- Reset (`reset_n`=0 at an edge): state IDLE, count 0, buffer/packet fields 0, `z80fi_valid` 0, `z80fi_order` 0, all err flags 0; open instruction discarded, no packet emitted. Inputs ignored on reset cycles.

## Test plan
- Start+byte 0xDD, next cycle byte 0x09, retire on cycle 3 -> cycle 4: valid=1, insn=0x000009DD, len=2, order=0, regs_in = start-cycle regs, regs_out = retire-cycle regs.
- Two instructions back to back (0x00 single-cycle, then 0xFD,0x29) -> orders 0 and 1, second insn=0x000029FD, len=2, upper bytes zero.
- Five bytes in one instruction -> len=4, insn holds first four bytes, `err_overflow`=1, packet still emitted.
- Retire in IDLE -> no valid pulse, `err_orphan`=1; start during OPEN without retire -> `err_abandon`=1, only the second instruction emitted.
- Retire+start+byte 0x3E same cycle after open 0xDD,0x19 -> packet insn=0x19DD; next instruction byte 0 = 0x3E, its regs_in = that cycle's regs.
- `reset_n` low mid-instruction -> no packet, order=0, flags 0; fresh instruction after reset emits order 0; ORDER_W=4 with 17 retires -> 17th packet order=0.

Source files
------------

// File: rtl/z80fi_insn_capture.sv
// Per-instruction formal-interface packet builder: gathers opcode bytes between
// start and retire, snapshots registers at both ends and emits a one-cycle packet.
module z80fi_insn_capture #(
    parameter int MAX_LEN = 4,
    parameter int ORDER_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   core_insn_start,
    input  logic                   core_byte_valid,
    input  logic [7:0]             core_byte,
    input  logic                   core_retire,
    input  logic [127:0]           core_regs,
    output logic                   z80fi_valid,
    output logic [8*MAX_LEN-1:0]   z80fi_insn,
    output logic [2:0]             z80fi_insn_len,
    output logic [127:0]           z80fi_regs_in,
    output logic [127:0]           z80fi_regs_out,
    output logic [ORDER_W-1:0]     z80fi_order,
    output logic                   err_overflow,
    output logic                   err_orphan,
    output logic                   err_abandon
);

    typedef enum logic {IDLE, OPEN} state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_LEN);

    state_t                 state;
    logic [8*MAX_LEN-1:0]   buf_q;
    logic [2:0]             cnt_q;
    logic [127:0]           regs_in_q;
    logic [ORDER_W-1:0]     order_q;

    logic [8*MAX_LEN-1:0]   acc_buf;
    logic [2:0]             acc_cnt;
    logic                   acc_ovf;
    logic [8*MAX_LEN-1:0]   open_buf;
    logic [2:0]             open_cnt;
    logic                   open_new;
    logic                   pkt_fire;
    logic [8*MAX_LEN-1:0]   pkt_buf;
    logic [2:0]             pkt_cnt;
    logic [127:0]           pkt_rin;
    logic                   orphan_now;
    logic                   abandon_now;

    // A byte arriving with a start belongs to the new instruction, never the open one.
    always_comb begin
        acc_buf = buf_q;
        acc_cnt = cnt_q;
        acc_ovf = 1'b0;
        if (state == OPEN && core_byte_valid && !core_insn_start) begin
            if (cnt_q < MAX_CNT) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (k == int'(cnt_q)) acc_buf[8*k +: 8] = core_byte;
                end
                acc_cnt = cnt_q + 3'd1;
            end else begin
                acc_ovf = 1'b1;
            end
        end

        open_buf = '0;
        open_cnt = 3'd0;
        if (core_byte_valid) begin
            open_buf[7:0] = core_byte;
            open_cnt      = 3'd1;
        end

        pkt_fire = 1'b0;
        pkt_buf  = acc_buf;
        pkt_cnt  = acc_cnt;
        pkt_rin  = regs_in_q;
        if (state == IDLE) begin
            pkt_fire = core_insn_start && core_retire && core_byte_valid;
            pkt_buf  = open_buf;
            pkt_cnt  = open_cnt;
            pkt_rin  = core_regs;
        end else begin
            pkt_fire = core_retire && (acc_cnt != 3'd0);
        end

        orphan_now  = core_retire && !pkt_fire;
        abandon_now = (state == OPEN) && core_insn_start && !core_retire;
        open_new    = core_insn_start && !(state == IDLE && core_retire);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            buf_q          <= '0;
            cnt_q          <= 3'd0;
            regs_in_q      <= '0;
            order_q        <= '0;
            z80fi_valid    <= 1'b0;
            z80fi_insn     <= '0;
            z80fi_insn_len <= 3'd0;
            z80fi_regs_in  <= '0;
            z80fi_regs_out <= '0;
            z80fi_order    <= '0;
            err_overflow   <= 1'b0;
            err_orphan     <= 1'b0;
            err_abandon    <= 1'b0;
        end else begin
            z80fi_valid <= pkt_fire;
            if (pkt_fire) begin
                z80fi_insn     <= pkt_buf;
                z80fi_insn_len <= pkt_cnt;
                z80fi_regs_in  <= pkt_rin;
                z80fi_regs_out <= core_regs;
                z80fi_order    <= order_q;
                order_q        <= order_q + ORDER_W'(1);
            end
            if (acc_ovf)     err_overflow <= 1'b1;
            if (orphan_now)  err_orphan   <= 1'b1;
            if (abandon_now) err_abandon  <= 1'b1;

            if (open_new) begin
                state     <= OPEN;
                buf_q     <= open_buf;
                cnt_q     <= open_cnt;
                regs_in_q <= core_regs;
            end else if (core_retire) begin
                state <= IDLE;
                cnt_q <= 3'd0;
            end else if (state == OPEN) begin
                buf_q <= acc_buf;
                cnt_q <= acc_cnt;
            end
        end
    end

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Table-driven bench for z80fi_insn_capture with a packet scoreboard; a second
// instance with ORDER_W=4 checks order-counter wrap.
module tb_z80fi_insn_capture;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         core_insn_start = 1'b0;
    logic         core_byte_valid = 1'b0;
    logic [7:0]   core_byte = 8'h00;
    logic         core_retire = 1'b0;
    logic [127:0] core_regs = '0;

    logic         z80fi_valid;
    logic [31:0]  z80fi_insn;
    logic [2:0]   z80fi_insn_len;
    logic [127:0] z80fi_regs_in;
    logic [127:0] z80fi_regs_out;
    logic [31:0]  z80fi_order;
    logic         err_overflow, err_orphan, err_abandon;

    logic         v4;
    logic [31:0]  insn4;
    logic [2:0]   len4;
    logic [127:0] rin4, rout4;
    logic [3:0]   order4;
    logic         ovf4, orph4, aban4;

    always #5 clk = ~clk;

    z80fi_insn_capture dut (
        .clk(clk), .reset_n(reset_n),
        .core_insn_start(core_insn_start), .core_byte_valid(core_byte_valid),
        .core_byte(core_byte), .core_retire(core_retire), .core_regs(core_regs),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_regs_in(z80fi_regs_in), .z80fi_regs_out(z80fi_regs_out), .z80fi_order(z80fi_order),
        .err_overflow(err_overflow), .err_orphan(err_orphan), .err_abandon(err_abandon)
    );

    z80fi_insn_capture #(.MAX_LEN(4), .ORDER_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .core_insn_start(core_insn_start), .core_byte_valid(core_byte_valid),
        .core_byte(core_byte), .core_retire(core_retire), .core_regs(core_regs),
        .z80fi_valid(v4), .z80fi_insn(insn4), .z80fi_insn_len(len4),
        .z80fi_regs_in(rin4), .z80fi_regs_out(rout4), .z80fi_order(order4),
        .err_overflow(ovf4), .err_orphan(orph4), .err_abandon(aban4)
    );

    typedef struct {
        bit          rn, st, bv, rt, pk;
        logic [7:0]  b;
        logic [31:0] insn;
        logic [2:0]  len;
        int          back;
        logic [2:0]  err;
    } vec_t;

    typedef struct {
        logic [31:0]  insn;
        logic [2:0]   len;
        logic [127:0] rin, rout;
        logic [31:0]  order;
    } pkt_t;

    vec_t         tbl[$];
    pkt_t         exp_q[$];
    logic [127:0] hist[$];
    logic [31:0]  exp_order = 0;
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic vec_t mk(bit rn, bit st, bit bv, logic [7:0] b, bit rt, bit pk,
                                logic [31:0] insn, logic [2:0] len, int back, logic [2:0] err);
        vec_t v;
        v.rn = rn; v.st = st; v.bv = bv; v.b = b; v.rt = rt; v.pk = pk;
        v.insn = insn; v.len = len; v.back = back; v.err = err;
        return v;
    endfunction

    function automatic logic [127:0] regs_of(int n);
        logic [31:0] a;
        a = 32'(n + 1) * 32'h9E37_79B9;
        return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'h1234_5678};
    endfunction

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [127:0] r;
        pkt_t p;
        @(negedge clk);
        r = regs_of(hist.size());
        hist.push_back(r);
        reset_n         = v.rn;
        core_insn_start = v.st;
        core_byte_valid = v.bv;
        core_byte       = v.b;
        core_retire     = v.rt;
        core_regs       = r;
        if (!v.rn) exp_order = 0;
        if (v.pk) begin
            p.insn  = v.insn;
            p.len   = v.len;
            p.rin   = hist[hist.size() - 1 - v.back];
            p.rout  = r;
            p.order = exp_order;
            exp_q.push_back(p);
            exp_order++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        pkt_t p;
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            cmp("valid", 128'(z80fi_valid), 128'(1));
            cmp("insn", 128'(z80fi_insn), 128'(p.insn));
            cmp("len", 128'(z80fi_insn_len), 128'(p.len));
            cmp("regs_in", z80fi_regs_in, p.rin);
            cmp("regs_out", z80fi_regs_out, p.rout);
            cmp("order", 128'(z80fi_order), 128'(p.order));
            cmp("order_w4", 128'(order4), 128'(p.order[3:0]));
        end else begin
            cmp("no_valid", 128'(z80fi_valid), 128'(0));
        end
        if (!v.rn) begin
            cmp("rst_order", 128'(z80fi_order), 128'(0));
            cmp("rst_insn", 128'(z80fi_insn), 128'(0));
        end
        cmp("err_flags", 128'({err_overflow, err_orphan, err_abandon}), 128'(v.err));
    endtask

    initial begin
        // rn st bv byte rt pk insn len back err{ovf,orph,aban}
        tbl.push_back(mk(0,0,0,8'h00,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,1,1,8'hDD,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,1,8'h09,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,0,8'h00,1,1,32'h0000_09DD,2,2,3'b000));
        tbl.push_back(mk(1,1,1,8'h00,1,1,32'h0000_0000,1,0,3'b000));
        tbl.push_back(mk(1,1,1,8'hFD,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,1,8'h29,1,1,32'h0000_29FD,2,1,3'b000));
        tbl.push_back(mk(1,1,1,8'h01,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,1,8'h02,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,1,8'h03,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,1,8'h04,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,1,8'h05,0,0,32'h0,0,0,3'b100));
        tbl.push_back(mk(1,0,0,8'h00,1,1,32'h0403_0201,4,5,3'b100));
        tbl.push_back(mk(1,0,0,8'h00,1,0,32'h0,0,0,3'b110));
        tbl.push_back(mk(1,1,1,8'h11,0,0,32'h0,0,0,3'b110));
        tbl.push_back(mk(1,1,1,8'h22,0,0,32'h0,0,0,3'b111));
        tbl.push_back(mk(1,0,0,8'h00,1,1,32'h0000_0022,1,1,3'b111));
        tbl.push_back(mk(1,1,1,8'hDD,0,0,32'h0,0,0,3'b111));
        tbl.push_back(mk(1,0,1,8'h19,0,0,32'h0,0,0,3'b111));
        tbl.push_back(mk(1,1,1,8'h3E,1,1,32'h0000_19DD,2,2,3'b111));
        tbl.push_back(mk(1,0,0,8'h00,1,1,32'h0000_003E,1,1,3'b111));
        tbl.push_back(mk(1,1,1,8'h77,0,0,32'h0,0,0,3'b111));
        tbl.push_back(mk(1,0,1,8'h88,0,0,32'h0,0,0,3'b111));
        tbl.push_back(mk(0,0,0,8'h00,1,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,1,8'h55,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,1,1,8'h44,1,1,32'h0000_0044,1,0,3'b000));
        tbl.push_back(mk(1,1,0,8'h00,0,0,32'h0,0,0,3'b000));
        tbl.push_back(mk(1,0,0,8'h00,1,0,32'h0,0,0,3'b010));
        tbl.push_back(mk(1,0,0,8'h00,0,0,32'h0,0,0,3'b010));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end

        // Reset, then 17 back-to-back single-cycle instructions to wrap the 4-bit counter.
        applyStimulus(mk(0,0,0,8'h00,0,0,32'h0,0,0,3'b000));
        checkOutput(mk(0,0,0,8'h00,0,0,32'h0,0,0,3'b000));
        for (int i = 0; i < 17; i++) begin
            applyStimulus(mk(1,1,1,8'(i + 8'h60),1,1,{24'h0, 8'(i + 8'h60)},1,0,3'b000));
            checkOutput(mk(1,1,1,8'(i + 8'h60),1,1,{24'h0, 8'(i + 8'h60)},1,0,3'b000));
        end
        cmp("wrap_order_w4", 128'(order4), 128'(0));
        cmp("wrap_order_w32", 128'(z80fi_order), 128'(16));

        applyStimulus(mk(1,0,0,8'h00,0,0,32'h0,0,0,3'b000));
        checkOutput(mk(1,0,0,8'h00,0,0,32'h0,0,0,3'b000));
        cmp("hold_insn", 128'(z80fi_insn), 128'(32'h70));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
